csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
- Machine-mode control/status register file.
- Responder end of the datapath's CSR interface: accepts the CSR address, write data and write-enable from the core.
- Returns the full slot array combinationally to the core (slot 3 = mtvec, slot 4 = mepc); the core uses these for the trap and return PCs.
- Owns trap-entry/return state updates, the cycle and instret counters, and interrupt-request generation.

Parameters:
- N, 64, data/register width.
- W_CSR, 256, number of slots in the output array.
- RESET_MTVEC, 0, mtvec value after reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears state immediately.
- csr_addr  in  12  CSR address (instr[31:20]).
- csr_in  in  N  write data.
- csr_we  in  1  CSR write enable.
- trap_trigger  in  1  take trap this cycle.
- trap_return  in  1  execute mret this cycle.
- pc  in  N  PC of the current instruction.
- fault_addr  in  N  data-memory address of the current instruction.
- except_f  in  4  fetch exception flags.
- except_e  in  7  execute exception flags.
- ext_irq  in  1  level external interrupt.
- instr_retire  in  1  current instruction completes.
- csr_out  out  N x [0:W_CSR-1]  slot array.
- irq_request  out  1  interrupt request to the trap logic.

Behaviour:
- Slot map (csr_addr -> slot):
  - 0x300 -> 0 mstatus
  - 0x304 -> 1 mie
  - 0x344 -> 2 mip
  - 0x305 -> 3 mtvec
  - 0x341 -> 4 mepc
  - 0x342 -> 5 mcause
  - 0x343 -> 6 mtval
  - 0x340 -> 7 mscratch
  - 0xB00 -> 8 mcycle
  - 0xB02 -> 9 minstret
  - Slots 10..W_CSR-1 read 0 always. Writes to unmapped addresses are ignored.
- Read path: csr_out is purely combinational from the registers, zero latency. A write is visible from the cycle after the edge.
- Reset (reset=0, async): all slots 0, except mtvec=RESET_MTVEC with bits[1:0] forced 0 and mstatus.MPP=2'b11. irq_request=0.
- Write masks:
  - mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits 0.
  - mie: only MEIE[11] is writable.
  - mip: read-only. MEIP[11] = ext_irq registered once (one-cycle delay).
  - mtvec, mepc: bits[1:0] forced 0.
  - mcause, mtval, mscratch: fully writable.
- mcycle: +1 every cycle, wraps at 2^N-1 -> 0. A csr_we to mcycle loads csr_in instead of incrementing that cycle.
- minstret: +1 when instr_retire=1 and trap_trigger=0, same wrap rule. A write has precedence over the increment.
- Trap entry (trap_trigger=1 at edge):
  - mepc <= pc with bits[1:0]=0.
  - mstatus.MPIE <= MIE, MIE <= 0.
  - mcause and mtval set per the priority below.
  - Any csr_we in the same cycle is suppressed.
- Cause priority, first match wins:
  - except_f[3] -> 3 (breakpoint), mtval = pc.
  - except_f[1] -> 1, mtval = pc.
  - except_f[0] -> 0, mtval = pc.
  - except_f[2] -> 2 (illegal), mtval = 0.
  - except_e[6] -> 3, mtval = pc.
  - except_e[4] -> 11 (ecall-M), mtval = 0.
  - except_e[0] -> 4, mtval = fault_addr.
  - except_e[1] -> 5, mtval = fault_addr.
  - except_e[2] -> 6, mtval = fault_addr.
  - except_e[3] -> 7, mtval = fault_addr.
  - except_e[5] -> 0 (misaligned branch target), mtval = fault_addr.
  - No flag set -> interrupt: mcause = {1'b1, (N-5)'b0, 4'd11}, mtval = 0.
- Trap return (trap_return=1 and trap_trigger=0): MIE <= MPIE, MPIE <= 1. A csr_we in the same cycle still applies to non-mstatus slots. If both trap_trigger and trap_return are 1, trap entry wins and the return is ignored.
- irq_request = mstatus.MIE & mie.MEIE & mip.MEIP. Combinational from registers; cleared by trap entry via MIE.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Counters restart from 0 on the first edge after release.

Test Plan:
- Reset release, RESET_MTVEC=0x1003: csr_out[3]=0x1000, csr_out[0]=0x1800, csr_out[8] reads 0 then 1, 2, 3 on successive edges.
- Write 0x305 with 0x8007, then write 0x300 with 0xFFFF_FFFF: csr_out[3]=0x8004, csr_out[0]=0x1888.
- MIE=1, pc=0x2006, except_e[0]=1, fault_addr=0x3001, trap_trigger=1, csr_we to 0x340 in the same cycle: mepc=0x2004, mcause=4, mtval=0x3001, MIE=0, MPIE=1, mscratch unchanged.
- Next cycle trap_return=1: MIE=1, MPIE=1. With trap_trigger=1 and trap_return=1 together: trap-entry result only.
- Write 0x304=0x800, MIE=1, ext_irq rises: irq_request=1 one cycle later. Then trap_trigger with no flags: mcause MSB=1, code 11, irq_request=0.
- mcycle written with all-ones: reads 0 the next cycle. instr_retire=1 with trap_trigger=1: minstret unchanged.

Source files
------------

// File: rtl/csr_file.sv
// ============================================================================
// csr_file -- machine-mode control/status register file
//
// Purpose:
//   Holds the M-mode CSRs the core needs for trap handling. It takes CSR
//   writes from the datapath, applies trap entry and mret updates, runs the
//   mcycle/minstret counters and raises the external interrupt request.
//   Every slot is returned combinationally as an array. The core reads its
//   trap PC from slot 3 (mtvec) and its return PC from slot 4 (mepc).
//
// Ports:
//   clk           rising-edge clock for all state
//   reset         asynchronous active-low reset
//   csr_addr      12-bit CSR address (instr[31:20])
//   csr_in        write data
//   csr_we        write enable
//   trap_trigger  take a trap at this edge
//   trap_return   execute mret at this edge (ignored if trap_trigger)
//   pc            PC of the current instruction
//   fault_addr    data-memory address of the current instruction
//   except_f      fetch exception flags
//   except_e      execute exception flags
//   ext_irq       level-sensitive external interrupt
//   instr_retire  current instruction completes
//   csr_out       slot array; 0..9 are mapped CSRs and the rest read 0
//   irq_request   MIE & MEIE & MEIP
// ============================================================================
module csr_file #(
    parameter int             N           = 64,
    parameter int             W_CSR       = 256,
    parameter logic [N-1:0]   RESET_MTVEC = '0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [11:0]    csr_addr,
    input  logic [N-1:0]   csr_in,
    input  logic           csr_we,
    input  logic           trap_trigger,
    input  logic           trap_return,
    input  logic [N-1:0]   pc,
    input  logic [N-1:0]   fault_addr,
    input  logic [3:0]     except_f,
    input  logic [6:0]     except_e,
    input  logic           ext_irq,
    input  logic           instr_retire,
    output logic [N-1:0]   csr_out [0:W_CSR-1],
    output logic           irq_request
);

    typedef enum logic [3:0] {
        SLOT_MSTATUS  = 4'd0,
        SLOT_MIE      = 4'd1,
        SLOT_MIP      = 4'd2,
        SLOT_MTVEC    = 4'd3,
        SLOT_MEPC     = 4'd4,
        SLOT_MCAUSE   = 4'd5,
        SLOT_MTVAL    = 4'd6,
        SLOT_MSCRATCH = 4'd7,
        SLOT_MCYCLE   = 4'd8,
        SLOT_MINSTRET = 4'd9,
        SLOT_NONE     = 4'd15
    } slot_e;

    localparam logic [N-1:0] MTVEC_RST = {RESET_MTVEC[N-1:2], 2'b00};
    localparam logic [N-1:0] IRQ_CAUSE = {1'b1, {(N-5){1'b0}}, 4'd11};

    // Only the architecturally meaningful bits are stored. The constant
    // fields (MPP, the low address bits) are reconstructed on the read path.
    logic           mstatus_mie_q, mstatus_mie_d;
    logic           mstatus_mpie_q, mstatus_mpie_d;
    logic           mie_meie_q, mie_meie_d;
    logic           mip_meip_q, mip_meip_d;
    logic [N-1:0]   mtvec_q, mtvec_d;
    logic [N-1:0]   mepc_q, mepc_d;
    logic [N-1:0]   mcause_q, mcause_d;
    logic [N-1:0]   mtval_q, mtval_d;
    logic [N-1:0]   mscratch_q, mscratch_d;
    logic [N-1:0]   mcycle_q, mcycle_d;
    logic [N-1:0]   minstret_q, minstret_d;

    slot_e          wr_slot;
    logic           wr_en;
    logic           retire_inc;
    logic [N-1:0]   trap_cause;
    logic [N-1:0]   trap_val;
    logic [N-1:0]   mstatus_rd;

    // Address decode
    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_slot = SLOT_NONE;
        unique case (csr_addr)
            12'h300: wr_slot = SLOT_MSTATUS;
            12'h304: wr_slot = SLOT_MIE;
            12'h344: wr_slot = SLOT_MIP;
            12'h305: wr_slot = SLOT_MTVEC;
            12'h341: wr_slot = SLOT_MEPC;
            12'h342: wr_slot = SLOT_MCAUSE;
            12'h343: wr_slot = SLOT_MTVAL;
            12'h340: wr_slot = SLOT_MSCRATCH;
            12'hB00: wr_slot = SLOT_MCYCLE;
            12'hB02: wr_slot = SLOT_MINSTRET;
            default: wr_slot = SLOT_NONE;
        endcase
    end

    // Trap cause and value. The first matching flag wins; no flag means an
    // interrupt.
    always_comb begin
        trap_cause = IRQ_CAUSE;
        trap_val   = '0;
        if      (except_f[3]) begin trap_cause = N'(3);  trap_val = pc;         end
        else if (except_f[1]) begin trap_cause = N'(1);  trap_val = pc;         end
        else if (except_f[0]) begin trap_cause = N'(0);  trap_val = pc;         end
        else if (except_f[2]) begin trap_cause = N'(2);  trap_val = '0;         end
        else if (except_e[6]) begin trap_cause = N'(3);  trap_val = pc;         end
        else if (except_e[4]) begin trap_cause = N'(11); trap_val = '0;         end
        else if (except_e[0]) begin trap_cause = N'(4);  trap_val = fault_addr; end
        else if (except_e[1]) begin trap_cause = N'(5);  trap_val = fault_addr; end
        else if (except_e[2]) begin trap_cause = N'(6);  trap_val = fault_addr; end
        else if (except_e[3]) begin trap_cause = N'(7);  trap_val = fault_addr; end
        else if (except_e[5]) begin trap_cause = N'(0);  trap_val = fault_addr; end
    end

    // Next-state logic. Precedence: trap entry > CSR write > counter
    // increment. mret overrides only mstatus.
    always_comb begin
        wr_en      = csr_we && !trap_trigger;
        retire_inc = instr_retire && !trap_trigger;

        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mip_meip_d     = ext_irq;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mscratch_d     = mscratch_q;
        mcycle_d       = mcycle_q + N'(1);
        minstret_d     = minstret_q + {{(N-1){1'b0}}, retire_inc};

        if (wr_en) begin
            unique case (wr_slot)
                SLOT_MSTATUS: begin
                    if (!trap_return) begin
                        mstatus_mie_d  = csr_in[3];
                        mstatus_mpie_d = csr_in[7];
                    end
                end
                SLOT_MIE:      mie_meie_d = csr_in[11];
                SLOT_MTVEC:    mtvec_d    = {csr_in[N-1:2], 2'b00};
                SLOT_MEPC:     mepc_d     = {csr_in[N-1:2], 2'b00};
                SLOT_MCAUSE:   mcause_d   = csr_in;
                SLOT_MTVAL:    mtval_d    = csr_in;
                SLOT_MSCRATCH: mscratch_d = csr_in;
                SLOT_MCYCLE:   mcycle_d   = csr_in;
                SLOT_MINSTRET: minstret_d = csr_in;
                default: ;  // mip is read-only and unmapped writes are dropped
            endcase
        end

        if (trap_trigger) begin
            mepc_d         = {pc[N-1:2], 2'b00};
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mcause_d       = trap_cause;
            mtval_d        = trap_val;
        end else if (trap_return) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its _d value as it was before this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mip_meip_q     <= 1'b0;
            mtvec_q        <= MTVEC_RST;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mscratch_q     <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mip_meip_q     <= mip_meip_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mscratch_q     <= mscratch_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

    // Read path. MPP is hard-wired to M-mode (2'b11).
    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mstatus_mpie_q;
        mstatus_rd[3]     = mstatus_mie_q;
    end

    always_comb begin
        for (int i = 0; i < W_CSR; i++) begin
            csr_out[i] = '0;
        end
        csr_out[0]     = mstatus_rd;
        csr_out[1]     = '0;
        csr_out[1][11] = mie_meie_q;
        csr_out[2]     = '0;
        csr_out[2][11] = mip_meip_q;
        csr_out[3]     = mtvec_q;
        csr_out[4]     = mepc_q;
        csr_out[5]     = mcause_q;
        csr_out[6]     = mtval_q;
        csr_out[7]     = mscratch_q;
        csr_out[8]     = mcycle_q;
        csr_out[9]     = minstret_q;
    end

    assign irq_request = mstatus_mie_q & mie_meie_q & mip_meip_q;

endmodule

// File: tb/tb_csr_file.sv
// ============================================================================
// tb_csr_file -- scoreboard bench for csr_file
//
// Stimulus drives inputs just after each rising edge and queues the values
// expected once that edge has taken effect. A separate monitor drains the
// queue on every falling edge and compares each entry against the DUT.
// Slot -1 in a queue entry stands for irq_request.
// ============================================================================
module tb_csr_file;

    localparam int N     = 64;
    localparam int W_CSR = 256;

    logic           clk = 1'b0;
    logic           reset;
    logic [11:0]    csr_addr;
    logic [N-1:0]   csr_in;
    logic           csr_we;
    logic           trap_trigger;
    logic           trap_return;
    logic [N-1:0]   pc;
    logic [N-1:0]   fault_addr;
    logic [3:0]     except_f;
    logic [6:0]     except_e;
    logic           ext_irq;
    logic           instr_retire;
    logic [N-1:0]   csr_out [0:W_CSR-1];
    logic           irq_request;

    typedef struct {
        string        name;
        int           slot;
        logic [N-1:0] value;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    csr_file #(
        .N           (N),
        .W_CSR       (W_CSR),
        .RESET_MTVEC (64'h1003)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .csr_addr     (csr_addr),
        .csr_in       (csr_in),
        .csr_we       (csr_we),
        .trap_trigger (trap_trigger),
        .trap_return  (trap_return),
        .pc           (pc),
        .fault_addr   (fault_addr),
        .except_f     (except_f),
        .except_e     (except_e),
        .ext_irq      (ext_irq),
        .instr_retire (instr_retire),
        .csr_out      (csr_out),
        .irq_request  (irq_request)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: the outputs depend only on registers, so sampling on the
    // falling edge is stable regardless of input changes.
    initial begin
        exp_t         e;
        logic [N-1:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = (e.slot < 0) ? {{(N-1){1'b0}}, irq_request} : csr_out[e.slot];
                check(e.name, act, e.value);
            end
        end
    end

    task automatic expect_slot(input string name, input int slot, input logic [N-1:0] v);
        exp_t e;
        e.name  = name;
        e.slot  = slot;
        e.value = v;
        sb.push_back(e);
    endtask

    task automatic idle();
        csr_addr     = '0;
        csr_in       = '0;
        csr_we       = 1'b0;
        trap_trigger = 1'b0;
        trap_return  = 1'b0;
        pc           = '0;
        fault_addr   = '0;
        except_f     = '0;
        except_e     = '0;
        instr_retire = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [N-1:0] d);
        csr_addr = a;
        csr_in   = d;
        csr_we   = 1'b1;
        step();
    endtask

    initial begin
        idle();
        ext_irq = 1'b0;
        reset   = 1'b0;
        #2;
        // Reset state
        expect_slot("rst_mtvec",   3,   64'h1000);
        expect_slot("rst_mstatus", 0,   64'h1800);
        expect_slot("rst_mcycle",  8,   64'h0);
        expect_slot("rst_mcause",  5,   64'h0);
        expect_slot("rst_slot255", 255, 64'h0);
        expect_slot("rst_irq",     -1,  64'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        expect_slot("mcycle_0", 8, 64'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            expect_slot($sformatf("mcycle_%0d", i), 8, N'(i));
        end

        // Write masks
        csr_write(12'h305, 64'h8007);
        expect_slot("mtvec_mask", 3, 64'h8004);
        csr_write(12'h300, 64'hFFFF_FFFF);
        expect_slot("mstatus_mask", 0, 64'h1888);
        csr_write(12'h344, '1);
        expect_slot("mip_readonly", 2, 64'h0);
        csr_write(12'h123, 64'hDEAD);
        expect_slot("unmapped_slot10", 10, 64'h0);
        expect_slot("unmapped_mtvec", 3, 64'h8004);
        csr_write(12'h340, 64'hABCD);
        expect_slot("mscratch_wr", 7, 64'hABCD);

        // Trap entry with a suppressed write in the same cycle
        pc           = 64'h2006;
        fault_addr   = 64'h3001;
        except_e     = 7'b000_0001;
        trap_trigger = 1'b1;
        csr_we       = 1'b1;
        csr_addr     = 12'h340;
        csr_in       = 64'h5555;
        step();
        expect_slot("trap_mepc",     4, 64'h2004);
        expect_slot("trap_mcause",   5, 64'd4);
        expect_slot("trap_mtval",    6, 64'h3001);
        expect_slot("trap_mstatus",  0, 64'h1880);
        expect_slot("trap_mscratch", 7, 64'hABCD);

        // mret; the mscratch write alongside it still lands
        trap_return = 1'b1;
        csr_we      = 1'b1;
        csr_addr    = 12'h340;
        csr_in      = 64'h77;
        step();
        expect_slot("mret_mstatus",  0, 64'h1888);
        expect_slot("mret_mscratch", 7, 64'h77);

        // Trap and mret together: entry wins
        trap_trigger = 1'b1;
        trap_return  = 1'b1;
        except_f     = 4'b1000;
        pc           = 64'h4000;
        step();
        expect_slot("both_mstatus", 0, 64'h1880);
        expect_slot("both_mcause",  5, 64'd3);
        expect_slot("both_mtval",   6, 64'h4000);
        expect_slot("both_mepc",    4, 64'h4000);

        // Cause priority spot checks
        trap_trigger = 1'b1;
        except_f     = 4'b0100;
        except_e     = 7'b111_1111;
        pc           = 64'h4444;
        fault_addr   = 64'h9999;
        step();
        expect_slot("illegal_mcause", 5, 64'd2);
        expect_slot("illegal_mtval",  6, 64'h0);
        trap_trigger = 1'b1;
        except_e     = 7'b001_0001;
        fault_addr   = 64'h9999;
        step();
        expect_slot("ecall_mcause", 5, 64'd11);
        expect_slot("ecall_mtval",  6, 64'h0);
        trap_trigger = 1'b1;
        except_e     = 7'b010_0000;
        fault_addr   = 64'h6002;
        step();
        expect_slot("brmis_mcause", 5, 64'd0);
        expect_slot("brmis_mtval",  6, 64'h6002);

        // External interrupt path
        csr_write(12'h304, '1);
        expect_slot("mie_mask", 1, 64'h800);
        csr_write(12'h300, 64'h8);
        expect_slot("mstatus_mie", 0, 64'h1808);
        ext_irq = 1'b1;
        expect_slot("irq_before", -1, 64'h0);
        expect_slot("mip_before", 2,  64'h0);
        step();
        expect_slot("mip_after", 2,  64'h800);
        expect_slot("irq_after", -1, 64'h1);
        trap_trigger = 1'b1;
        pc           = 64'h5008;
        step();
        expect_slot("irq_mcause",  5,  64'h8000_0000_0000_000B);
        expect_slot("irq_mtval",   6,  64'h0);
        expect_slot("irq_mepc",    4,  64'h5008);
        expect_slot("irq_mstatus", 0,  64'h1880);
        expect_slot("irq_cleared", -1, 64'h0);

        // Counter wrap and precedence
        csr_write(12'hB00, '1);
        expect_slot("mcycle_ones", 8, '1);
        step();
        expect_slot("mcycle_wrap", 8, 64'h0);
        instr_retire = 1'b1;
        csr_write(12'hB02, 64'h10);
        expect_slot("minstret_wr", 9, 64'h10);
        instr_retire = 1'b1;
        trap_trigger = 1'b1;
        step();
        expect_slot("minstret_trap", 9, 64'h10);
        instr_retire = 1'b1;
        step();
        expect_slot("minstret_inc", 9, 64'h11);
        instr_retire = 1'b1;
        csr_write(12'hB02, '1);
        instr_retire = 1'b1;
        step();
        expect_slot("minstret_wrap", 9, 64'h0);

        // Asynchronous reset mid-operation
        csr_write(12'h300, 64'h8);
        expect_slot("irq_rearm", -1, 64'h1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        expect_slot("mid_mstatus", 0,  64'h1800);
        expect_slot("mid_mtvec",   3,  64'h1000);
        expect_slot("mid_mcause",  5,  64'h0);
        expect_slot("mid_mie",     1,  64'h0);
        expect_slot("mid_irq",     -1, 64'h0);
        step();
        reset = 1'b1;
        expect_slot("mid_mcycle_0", 8, 64'h0);
        step();
        expect_slot("mid_mcycle_1", 8, 64'h1);

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
